// File: rtl/tele_rx.sv
// tele_rx: serial byte-frame receiver for the tele link.
//
// Recovers frames of the form start bit (low), DATA_W data bits LSB first and
// one stop bit (high) from an asynchronous serial line. Each bit lasts OVS
// src_clk cycles. The line is oversampled on src_clk and every bit is sampled
// at its midpoint. OVS must be even and at least 4.
//
// Ports:
//   src_clk      - the only clock; all logic uses its rising edge
//   rst_src_n    - synchronous, active-low reset
//   rx_in        - serial line, asynchronous to src_clk, idles high
//   rx_data      - last byte received with a good stop bit; bit 0 arrived first
//   rx_valid     - one-cycle strobe: rx_data was updated in this cycle
//   rx_frame_err - one-cycle strobe: the stop bit was sampled low
//   rx_busy      - high whenever a frame is being received (FSM not IDLE)

module tele_rx #(
    parameter int DATA_W = 8,
    parameter int OVS    = 16
) (
    input  logic              src_clk,
    input  logic              rst_src_n,
    input  logic              rx_in,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_frame_err,
    output logic              rx_busy
);

    localparam int CNT_W = (OVS > 1) ? $clog2(OVS) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVS / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic s1;
    logic s2;
    logic s2_d;
    logic sync_primed;
    logic armed;

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [IDX_W-1:0]  bit_idx_q;
    logic [IDX_W-1:0]  bit_idx_d;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_d;
    logic [DATA_W-1:0] rx_data_d;
    logic              rx_valid_d;
    logic              rx_frame_err_d;

    // Two-flop synchronizer plus one delay flop for falling-edge detection.
    // The flops reset to the idle (high) level, so a line that is already low
    // when reset is released would look like a falling edge in s2/s2_d.
    // 'armed' stays low until s1 has captured a real high level from the line
    // after reset, which keeps a reset in the middle of a frame from starting
    // a bogus frame on the remainder of that frame.
    always_ff @(posedge src_clk) begin
        if (!rst_src_n) begin
            s1          <= 1'b1;
            s2          <= 1'b1;
            s2_d        <= 1'b1;
            sync_primed <= 1'b0;
            armed       <= 1'b0;
        end else begin
            s1          <= rx_in;
            s2          <= s1;
            s2_d        <= s2;
            sync_primed <= 1'b1;
            if (sync_primed && s1) begin
                armed <= 1'b1;
            end
        end
    end

    // State, counters, shift register and the registered outputs.
    always_ff @(posedge src_clk) begin
        if (!rst_src_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            rx_data      <= rx_data_d;
            rx_valid     <= rx_valid_d;
            rx_frame_err <= rx_frame_err_d;
        end
    end

    // Next-state logic. START waits half a bit so that every later sample,
    // taken a full bit time apart, lands on a bit midpoint. STOP leaves at
    // the stop-bit midpoint, which leaves half a bit of IDLE time before a
    // back-to-back start bit can arrive.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bit_idx_d      = bit_idx_q;
        shreg_d        = shreg_q;
        rx_data_d      = rx_data;
        rx_valid_d     = 1'b0;
        rx_frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (armed && s2_d && !s2) begin
                    state_d = START;
                end
            end

            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (s2) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = (shreg_q >> 1) | (DATA_W'(s2) << (DATA_W - 1));
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (s2) begin
                        rx_data_d  = shreg_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_tele_rx.sv
// tb_tele_rx: self-checking bench for tele_rx.
//
// The bench drives the serial line one src_clk cycle at a time and keeps a
// reference model built from the frame timing rules: a frame whose start bit
// is first captured at edge E produces its strobe after edge E+154 (at the
// default parameters) and keeps rx_busy high after edges E+2 .. E+153. A
// false start keeps rx_busy high for OVS/2 cycles. The model holds a queue of
// expected strobes and a list of busy windows; every cycle the outputs are
// compared against it.

module tb_tele_rx;

    localparam int DATA_W     = 8;
    localparam int OVS        = 16;
    localparam int STROBE_LAT = 2 + OVS / 2 + OVS * (DATA_W + 1);

    logic              src_clk = 1'b0;
    logic              rst_src_n = 1'b0;
    logic              rx_in = 1'b1;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_frame_err;
    logic              rx_busy;

    tele_rx #(
        .DATA_W(DATA_W),
        .OVS   (OVS)
    ) dut (
        .src_clk     (src_clk),
        .rst_src_n   (rst_src_n),
        .rx_in       (rx_in),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err),
        .rx_busy     (rx_busy)
    );

    always #5 src_clk = ~src_clk;

    typedef struct {
        int         cycle;
        bit         isErr;
        logic [7:0] data;
    } ev_t;

    ev_t        evQ[$];
    int         busyLo[$];
    int         busyHi[$];
    int         cyc = 0;
    logic [7:0] modelData = 8'h00;
    int         assertCount = 0;
    int         failCount = 0;

    // Compare all outputs against the model for the current cycle. A cycle in
    // which reset was applied wipes the model back to its reset state.
    task automatic checkOutput();
        logic expValid;
        logic expErr;
        logic expBusy;
        ev_t  ev;
        expValid = 1'b0;
        expErr   = 1'b0;
        expBusy  = 1'b0;
        if (!rst_src_n) begin
            evQ.delete();
            busyLo.delete();
            busyHi.delete();
            modelData = 8'h00;
        end
        while (evQ.size() > 0 && evQ[0].cycle < cyc) begin
            void'(evQ.pop_front());
        end
        if (evQ.size() > 0 && evQ[0].cycle == cyc) begin
            ev = evQ.pop_front();
            if (ev.isErr) begin
                expErr = 1'b1;
            end else begin
                expValid  = 1'b1;
                modelData = ev.data;
            end
        end
        foreach (busyLo[i]) begin
            if (cyc >= busyLo[i] && cyc <= busyHi[i]) expBusy = 1'b1;
        end

        assertCount++;
        assert (rx_valid === expValid) else begin
            failCount++;
            $error("[TB] FAIL rx_valid cyc=%0d observed=%b expected=%b", cyc, rx_valid, expValid);
        end
        assertCount++;
        assert (rx_frame_err === expErr) else begin
            failCount++;
            $error("[TB] FAIL rx_frame_err cyc=%0d observed=%b expected=%b", cyc, rx_frame_err, expErr);
        end
        assertCount++;
        assert (rx_busy === expBusy) else begin
            failCount++;
            $error("[TB] FAIL rx_busy cyc=%0d observed=%b expected=%b", cyc, rx_busy, expBusy);
        end
        assertCount++;
        assert (rx_data === modelData) else begin
            failCount++;
            $error("[TB] FAIL rx_data cyc=%0d observed=%h expected=%h", cyc, rx_data, modelData);
        end
    endtask

    task automatic tick();
        @(posedge src_clk);
        cyc++;
        #1;
        checkOutput();
    endtask

    task automatic idleLine(input logic level, input int n);
        for (int i = 0; i < n; i++) begin
            rx_in = level;
            tick();
        end
    endtask

    // Send one frame. resetBit >= 0 pulses reset for one cycle at the start of
    // that frame bit (0 = start bit, 1..8 = data bits, 9 = stop bit).
    task automatic applyStimulus(input logic [7:0] data, input bit stopBit, input int resetBit);
        logic [9:0] bits;
        ev_t        ev;
        int         e;
        bits     = {stopBit, data, 1'b0};
        e        = cyc + 1;
        ev.cycle = e + STROBE_LAT;
        ev.isErr = !stopBit;
        ev.data  = data;
        evQ.push_back(ev);
        busyLo.push_back(e + 2);
        busyHi.push_back(e + STROBE_LAT - 1);
        for (int b = 0; b < 10; b++) begin
            for (int j = 0; j < OVS; j++) begin
                rx_in = bits[b];
                if (b == resetBit && j == 0) rst_src_n = 1'b0;
                tick();
                rst_src_n = 1'b1;
            end
        end
    endtask

    // Short low pulse that must be rejected at the start-bit midpoint check.
    task automatic glitchLow(input int n);
        int e;
        e = cyc + 1;
        busyLo.push_back(e + 2);
        busyHi.push_back(e + 1 + OVS / 2);
        idleLine(1'b0, n);
        rx_in = 1'b1;
    endtask

    initial begin
        logic [7:0] d;
        bit         stopBit;
        bit         prevStop;
        int         gap;

        $display("[TB] tele_rx bench start");
        rst_src_n = 1'b0;
        rx_in     = 1'b1;
        tick();
        tick();
        rst_src_n = 1'b1;

        idleLine(1'b1, 200);

        applyStimulus(8'hA5, 1'b1, -1);
        idleLine(1'b1, 20);

        glitchLow(5);
        idleLine(1'b1, 30);

        applyStimulus(8'h3C, 1'b0, -1);
        idleLine(1'b0, 400);
        idleLine(1'b1, 20);
        applyStimulus(8'h5A, 1'b1, -1);
        idleLine(1'b1, 10);

        applyStimulus(8'h00, 1'b1, -1);
        applyStimulus(8'hFF, 1'b1, -1);
        idleLine(1'b1, 10);

        applyStimulus(8'h81, 1'b1, 5);
        idleLine(1'b1, 20);
        applyStimulus(8'h7E, 1'b1, -1);
        idleLine(1'b1, 20);

        prevStop = 1'b1;
        for (int n = 0; n < 10; n++) begin
            d       = 8'($urandom_range(0, 255));
            stopBit = ($urandom_range(0, 3) != 0);
            gap     = prevStop ? int'($urandom_range(0, 15)) : 1 + int'($urandom_range(0, 15));
            idleLine(1'b1, gap);
            applyStimulus(d, stopBit, -1);
            prevStop = stopBit;
        end
        idleLine(1'b1, 200);

        assertCount++;
        assert (evQ.size() === 0) else begin
            failCount++;
            $error("[TB] FAIL pending_events observed=%0d expected=0", evQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
